mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle RISC-V control FSM with memory-wait timeout and sticky fault.
// Optional: define MC_BRANCH_EN to enable BEQ/BNE resolution in EXEC.
module mc_control_unit #(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned ALU_CC_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                instr_fetch,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic [2:0]          state,
  output logic                fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BR
  } cls_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
`ifdef MC_BRANCH_EN
  localparam logic [6:0] OP_BR = 7'b1100011;
`endif

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [7:0] wait_q, wait_d;
  logic [8:0] wait_inc;
  logic       timeout;
  logic [3:0] cc4;

  assign wait_inc = {1'b0, wait_q} + 9'd1;
  assign timeout  = (wait_inc >= 9'(TIMEOUT));

  // Counter only survives consecutive unacknowledged memory cycles.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          wait_d = wait_inc[7:0];
          if (timeout) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        unique case (1'b1)
          (opcode == OP_R):  cls_d = C_R;
          (opcode == OP_I):  cls_d = C_I;
          (opcode == OP_LW): cls_d = C_LW;
          (opcode == OP_SW): cls_d = C_SW;
`ifdef MC_BRANCH_EN
          (opcode == OP_BR): begin
            cls_d = C_BR;
            if (funct3[2:1] != 2'b00) state_d = S_FAULT;
          end
`endif
          default: state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_LW, C_SW: state_d = S_MEM;
          C_BR:       state_d = S_FETCH;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
        end else begin
          wait_d = wait_inc[7:0];
          if (timeout) state_d = S_FAULT;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    cc4 = 4'b0010;
    case (cls_q)
      C_BR: cc4 = 4'b0110;
      C_R, C_I: begin
        case (funct3)
          3'b000: begin
            if (cls_q == C_R && funct7 == 7'b0100000)
              cc4 = 4'b0110;
          end
          3'b100:  cc4 = 4'b1100;
          3'b110:  cc4 = 4'b0001;
          3'b111:  cc4 = 4'b0000;
          3'b010:  cc4 = 4'b0111;
          default: cc4 = 4'b0010;
        endcase
      end
      default: cc4 = 4'b0010;
    endcase
  end

  // Everything is forced low while reset is held.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem2reg     = 1'b0;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    instr_fetch = 1'b0;
    alu_cc      = '0;
    state       = 3'd0;
    fault       = 1'b0;
    if (reset) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          instr_fetch = 1'b1;
          mem_read    = 1'b1;
          ir_write    = mem_ready;
        end
        S_DECODE: ;
        S_EXEC: begin
          alu_src = (cls_q == C_I) || (cls_q == C_LW) ||
                    (cls_q == C_SW);
          alu_cc  = ALU_CC_W'(cc4);
          if (cls_q == C_BR)
            pc_write = funct3[0] ? !zero : zero;
        end
        S_MEM: begin
          alu_cc    = ALU_CC_W'(cc4);
          mem_read  = (cls_q == C_LW);
          mem_write = (cls_q == C_SW);
          pc_write  = (cls_q == C_SW) && mem_ready;
        end
        S_WB: begin
          alu_cc    = ALU_CC_W'(cc4);
          reg_write = 1'b1;
          pc_write  = 1'b1;
          mem2reg   = (cls_q == C_LW);
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule
